lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
// - Load/store unit between the single-cycle core datapath data port and a handshaked data-memory bus.
// - Converts a RISC-V load/store (funct3 size/sign) into a word-aligned bus transaction with byte enables.
// - Returns aligned, extended load data to the datapath and stalls the core until the bus completes.
// - Detects misaligned or unsupported accesses without touching the bus.
// PARAMETERS
// - WIDTH    32   data width; only 32 is supported
// - DADDR    10   byte address width, shared by the core and the bus
// - TIMEOUT  64   bus-ack watchdog limit in cycles; used only with LSU_TIMEOUT_EN
// PORTS
// - clk        in   1      clock, rising edge
// - reset      in   1      synchronous, active-high reset
// - ld_en      in   1      core issues a load this cycle
// - st_en      in   1      core issues a store this cycle; never high together with ld_en
// - funct3     in   3      access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
// - core_addr  in   DADDR  byte address, which is the datapath ALU result
// - core_wdata in   WIDTH  store data, which is rs2
// - core_rdata out  WIDTH  load result, extended and right-justified
// - stall      out  1      core must hold PC and register-file write
// - fault      out  1      misaligned access or unsupported funct3; one-cycle pulse
// - bus_req    out  1      bus request, registered
// - bus_we     out  1      1 = write
// - bus_addr   out  DADDR  word address; bits [1:0] are always 0
// - bus_be     out  4      byte enables
// - bus_wdata  out  WIDTH  lane-replicated write data
// - bus_ack    in   1      transfer complete; bus_rdata is valid on a load
// - bus_rdata  in   WIDTH  read word
// - bus_err    out  1      watchdog abort pulse; tied 0 without LSU_TIMEOUT_EN
// BEHAVIOUR
// - Reset: state = IDLE. bus_req, bus_we, bus_be, bus_addr, bus_wdata, core_rdata, fault and bus_err are all 0.
// - FSM states: IDLE, REQ, DONE.
// - IDLE, with ld_en|st_en and an aligned, legal access:
//   - latch addr/be/wdata/we/funct3; next state REQ.
//   - bus_req is asserted from the next cycle.
// - IDLE, with an illegal access:
//   - fault=1 for that cycle only; stall=0; no bus activity.
//   - A load returns core_rdata=0. State stays IDLE.
// - REQ: bus_req=1; addr, be, wdata and we are held stable until bus_ack is sampled high.
// - REQ, on bus_ack:
//   - load: capture the extended read data into the core_rdata register.
//   - bus_req drops the next cycle; next state DONE.
// - DONE: stall=0 so the core retires the instruction; next state IDLE unconditionally.
// - stall is combinational: stall = (ld_en|st_en) & legal & (state != DONE).
// - Minimum latency is 3 cycles (IDLE, REQ with ack, DONE), giving 2 stall cycles.
// - Each additional ack wait adds one stall cycle.
// - bus_ack while bus_req=0 is ignored. An ack in the cycle after reset is ignored.
// - Alignment rules:
//   - LH/LHU/SH require addr[0]=0.
//   - LW/SW require addr[1:0]=00.
//   - Byte accesses are always aligned.
//   - funct3 011/110/111 are illegal, as are 100/101 on a store.
// - Byte enables and write data:
//   - SB: be = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
//   - SH: be = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
//   - SW: be = 1111; wdata = rs2.
// - Load data:
//   - Select byte/half by the latched addr[1:0].
//   - LB/LH sign-extend to 32; LBU/LHU zero-extend.
//   - core_rdata holds its value until the next completed load.
// - Reset mid-transaction: return to IDLE; bus_req=0 on the next edge; the pending access is abandoned.
// CONFIGURATION
// - LSU_TIMEOUT_EN defined:
//   - A counter runs in REQ. If TIMEOUT cycles pass without an ack, the transaction aborts.
//   - On abort: bus_req drops, bus_err pulses 1 cycle, core_rdata=0, state goes to DONE and the core proceeds.
//   - Any late ack is ignored.
// - LSU_TIMEOUT_EN undefined:
//   - No counter; REQ waits indefinitely; bus_err is constant 0.
// TESTING
// - LW, addr 0x010, ack in first REQ cycle, bus_rdata 0xDEADBEEF
//   -> bus_addr 0x010, be 1111, stall 2 cycles, core_rdata 0xDEADBEEF.
// - SB, addr 0x013, rs2 0x000000A5, ack after 3 wait cycles
//   -> be 1000, wdata 0xA5A5A5A5, bus_we=1, stall 5 cycles.
// - LB then LBU, addr 0x022, bus_rdata 0x0080_0000 -> 0xFFFFFF80, then 0x00000080.
// - LH at 0x031 and SW at 0x006 -> fault pulse each, bus_req stays 0, stall 0, core_rdata=0 on the LH.
// - reset asserted in REQ with ack withheld -> next cycle bus_req=0, state IDLE; a later ack has no effect.
// - LSU_TIMEOUT_EN with TIMEOUT=8, ack never given -> bus_err pulse after 8 REQ cycles, core_rdata=0, stall released.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: maps RISC-V funct3 loads/stores onto a word-aligned req/ack bus, stalling the core until completion.
// Optional bus-ack watchdog is compiled in with the LSU_TIMEOUT_EN macro.
module lsu #(
   parameter int WIDTH   = 32,
   parameter int DADDR   = 10,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_en,
   input  logic             st_en,
   input  logic [2:0]       funct3,
   input  logic [DADDR-1:0] core_addr,
   input  logic [WIDTH-1:0] core_wdata,
   output logic [WIDTH-1:0] core_rdata,
   output logic             stall,
   output logic             fault,
   output logic             bus_req,
   output logic             bus_we,
   output logic [DADDR-1:0] bus_addr,
   output logic [3:0]       bus_be,
   output logic [WIDTH-1:0] bus_wdata,
   input  logic             bus_ack,
   input  logic [WIDTH-1:0] bus_rdata,
   output logic             bus_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_we_q, bus_we_d;
   logic             bus_err_q, bus_err_d;
   logic [DADDR-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]       bus_be_q, bus_be_d;
   logic [WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d;

   logic             access;
   logic             legal;
   logic [3:0]       be_new;
   logic [WIDTH-1:0] wdata_new;
   logic [WIDTH-1:0] rd_shift;
   logic [WIDTH-1:0] ld_ext;

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
`else
   logic             unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   always_comb begin
      access = ld_en | st_en;
      case (funct3)
         3'b000:  legal = 1'b1;
         3'b001:  legal = ~core_addr[0];
         3'b010:  legal = (core_addr[1:0] == 2'b00);
         3'b100:  legal = ld_en;
         3'b101:  legal = ld_en & ~core_addr[0];
         default: legal = 1'b0;
      endcase

      case (funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << core_addr[1:0];
            wdata_new = {4{core_wdata[7:0]}};
         end
         2'b01: begin
            be_new    = core_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{core_wdata[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = core_wdata;
         end
      endcase

      // Byte/half lanes are right-justified by the offset latched at issue
      rd_shift = bus_rdata >> {off_q, 3'b000};
      case (f3_q[1:0])
         2'b00:   ld_ext = {{24{~f3_q[2] & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_ext = {{16{~f3_q[2] & rd_shift[15]}}, rd_shift[15:0]};
         default: ld_ext = bus_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_err_d   = 1'b0;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      f3_d        = f3_q;
      off_d       = off_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (access && legal) begin
               state_d     = REQ;
               bus_req_d   = 1'b1;
               bus_we_d    = st_en;
               bus_addr_d  = {core_addr[DADDR-1:2], 2'b00};
               bus_be_d    = be_new;
               bus_wdata_d = wdata_new;
               f3_d        = funct3;
               off_d       = core_addr[1:0];
`ifdef LSU_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         REQ: begin
            if (bus_ack && bus_req_q) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               if (!bus_we_q) rdata_d = ld_ext;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               rdata_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_err_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         rdata_q     <= '0;
         f3_q        <= '0;
         off_q       <= '0;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_err_q   <= bus_err_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign stall      = access & legal & (state_q != DONE);
   assign fault      = access & ~legal & (state_q == IDLE);
   assign core_rdata = (fault & ld_en) ? '0 : rdata_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed spec scenarios followed by randomized loads/stores against an arithmetic access model.
module tb_lsu;
   localparam int TMO = 8;
`ifdef LSU_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_en, st_en;
   logic [2:0]  funct3;
   logic [9:0]  core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        stall, fault;
   logic        bus_req, bus_we;
   logic [9:0]  bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_ld;
   logic [31:0] obs_addr, obs_be, obs_wd, obs_we, obs_rd, obs_fault, obs_err;
   int          obs_stalls;

   lsu #(.WIDTH(32), .DADDR(10), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
      .stall(stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One core instruction; the bench acts as the bus slave, acking after ack_wait REQ cycles.
   task automatic access(input bit is_ld, input logic [2:0] f3, input logic [9:0] addr,
                         input logic [31:0] wd, input int ack_wait, input logic [31:0] rd);
      int          a, bytes, waits, exp_stalls;
      bit          legal, done, tmo_case;
      logic [31:0] exp_be, exp_wd, exp_ld, v;
      a     = int'(addr);
      bytes = 1 << f3[1:0];
      legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (is_ld && (f3 == 3'd4 || f3 == 3'd5)))
              && (a % bytes == 0);
      tmo_case   = TMO_ON && legal && (ack_wait >= TMO);
      exp_stalls = !legal ? 0 : (tmo_case ? 1 + TMO : 2 + ack_wait);
      exp_be = ((32'd1 << bytes) - 1) << (a % 4);
      if (bytes == 1)      exp_wd = (wd & 32'hFF) * 32'h01010101;
      else if (bytes == 2) exp_wd = (wd & 32'hFFFF) * 32'h00010001;
      else                 exp_wd = wd;
      v = rd >> (8 * (a % 4));
      if (bytes < 4) begin
         v = v & ((32'd1 << (8 * bytes)) - 1);
         if (!f3[2] && v[8*bytes-1]) v = v - (32'd1 << (8 * bytes));
      end
      exp_ld = tmo_case ? 32'd0 : v;

      obs_addr = 0; obs_be = 0; obs_wd = 0; obs_we = 0;
      @(negedge clk);
      ld_en = is_ld; st_en = !is_ld; funct3 = f3; core_addr = addr; core_wdata = wd;
      bus_ack = 1'b0; bus_rdata = rd;
      obs_stalls = 0; waits = 0; done = 0;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         #1;
         if (!stall) begin
            done = 1;
         end else begin
            obs_stalls++;
            chk("req_timing", bus_req, cyc > 0);
            bus_ack = 1'b0;
            if (bus_req) begin
               if (waits == 0) begin
                  obs_addr = bus_addr; obs_be = bus_be; obs_wd = bus_wdata; obs_we = bus_we;
               end
               chk("bus_addr", bus_addr, addr & 10'h3FC);
               chk("bus_be", bus_be, exp_be);
               chk("bus_we", bus_we, !is_ld);
               if (!is_ld) chk("bus_wdata", bus_wdata, exp_wd);
               if (waits == ack_wait) bus_ack = 1'b1;
               waits++;
            end
            @(negedge clk);
         end
      end
      if (!done) chk("retire_bound", 0, 1);
      obs_rd = core_rdata; obs_fault = fault; obs_err = bus_err;
      chk("stall_cycles", obs_stalls, exp_stalls);
      chk("fault", fault, !legal);
      chk("bus_req_idle", bus_req, 0);
      chk("bus_err", bus_err, tmo_case);
      if (is_ld && legal) last_ld = exp_ld;
      if (is_ld && !legal) chk("fault_rdata", core_rdata, 0);
      else                 chk("core_rdata", core_rdata, last_ld);
      @(negedge clk);
      ld_en = 1'b0; st_en = 1'b0; bus_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ld_en = 0; st_en = 0; funct3 = 0; core_addr = 0; core_wdata = 0;
      bus_ack = 0; bus_rdata = 0; last_ld = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_be", bus_be, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_core_rdata", core_rdata, 0);
      chk("rst_fault", fault, 0);
      chk("rst_bus_err", bus_err, 0);
      reset = 1'b0;
      bus_ack = 1'b1;
      @(negedge clk); #1;
      chk("ack_after_reset", bus_req, 0);
      bus_ack = 1'b0;

      access(1, 3'b010, 10'h010, 32'h0, 0, 32'hDEADBEEF);
      chk("lw_addr", obs_addr, 32'h010);
      chk("lw_be", obs_be, 32'h0F);
      chk("lw_stalls", obs_stalls, 2);
      chk("lw_rdata", obs_rd, 32'hDEADBEEF);

      access(0, 3'b000, 10'h013, 32'h000000A5, 3, 32'h0);
      chk("sb_be", obs_be, 32'h08);
      chk("sb_wdata", obs_wd, 32'hA5A5A5A5);
      chk("sb_we", obs_we, 1);
      chk("sb_stalls", obs_stalls, 5);

      access(1, 3'b000, 10'h022, 32'h0, 1, 32'h00800000);
      chk("lb_rdata", obs_rd, 32'hFFFFFF80);
      access(1, 3'b100, 10'h022, 32'h0, 0, 32'h00800000);
      chk("lbu_rdata", obs_rd, 32'h00000080);

      access(1, 3'b001, 10'h031, 32'h0, 0, 32'h12345678);
      chk("lh_mis_fault", obs_fault, 1);
      chk("lh_mis_stalls", obs_stalls, 0);
      chk("lh_mis_rdata", obs_rd, 0);
      access(0, 3'b010, 10'h006, 32'hCAFEF00D, 0, 32'h0);
      chk("sw_mis_fault", obs_fault, 1);
      chk("sw_mis_stalls", obs_stalls, 0);

      // Reset while REQ is waiting for an ack that never comes
      @(negedge clk);
      ld_en = 1; funct3 = 3'b010; core_addr = 10'h050; bus_ack = 0; bus_rdata = 32'h12345678;
      repeat (3) @(negedge clk);
      #1 chk("mid_req_active", bus_req, 1);
      reset = 1'b1; ld_en = 0;
      @(negedge clk); #1;
      chk("mid_rst_req", bus_req, 0);
      reset = 1'b0; bus_ack = 1'b1;
      @(negedge clk); #1;
      chk("late_ack_req", bus_req, 0);
      chk("late_ack_rdata", core_rdata, 0);
      bus_ack = 1'b0;
      last_ld = 0;
      access(1, 3'b101, 10'h046, 32'h0, 2, 32'h8001_7FFF);
      chk("lhu_rdata", obs_rd, 32'h00008001);

      if (TMO_ON) begin
         access(1, 3'b010, 10'h040, 32'h0, 1000, 32'h55AA55AA);
         chk("tmo_stalls", obs_stalls, 1 + TMO);
         chk("tmo_err", obs_err, 1);
         chk("tmo_rdata", obs_rd, 0);
      end

      for (int i = 0; i < 60; i++) begin
         access($urandom_range(0, 1), 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
                $urandom, $urandom_range(0, 4), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
